// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative signed multiply / divide engine for the ALU MUL and DIV
// opcodes. One result bit is produced per clock through a single shared
// (WIDTH+1)-bit adder/subtractor.
//
// Ports:
//   clock      rising-edge clock
//   reset_n    asynchronous active-low reset
//   start      operation request, accepted only while busy=0 and in IDLE
//   div        operation select sampled with start: 0=MUL, 1=DIV
//   A, B       two's complement operands sampled with start
//   out        MUL: signed product {HI,LO}; DIV: {remainder, quotient}
//   busy       high from the accepting edge until the result is written
//   finished   one-cycle completion pulse; out is valid from that cycle on
//   div_zero   set with finished when a DIV had B=0; cleared on next accept
//   state_dbg  current FSM state (0=IDLE, 1=CALC, 2=DONE) for observation
//
// Handshake: start is a request sampled on the rising edge; it is taken only
// when the unit is in IDLE (busy=0 and not in the DONE cycle). A start seen at
// any other time is dropped, not queued. Operands need only be valid on the
// accepting edge. Completion is signalled by a single-cycle finished pulse.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               start,
  input  logic               div,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic [2*WIDTH-1:0] out,
  output logic               busy,
  output logic               finished,
  output logic               div_zero,
  output logic [1:0]         state_dbg
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state, state_next;

  logic [CW-1:0]    count;
  // hi: Booth accumulator (MUL) or partial remainder (DIV). One guard bit so
  //     the most negative multiplicand and the shifted remainder never overflow.
  // lo: multiplier (MUL) or dividend magnitude turning into quotient (DIV).
  // m : sign-extended multiplicand (MUL) or zero-extended |divisor| (DIV).
  logic [WIDTH:0]   hi;
  logic [WIDTH:0]   m;
  logic [WIDTH-1:0] lo;
  logic             q_1;
  logic             op_div;
  logic             dz;
  logic             neg_q;
  logic             neg_r;

  logic             accept;
  logic             last_step;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   add_a;
  logic             add_sub;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   booth_hi;
  logic [WIDTH-1:0] quot;
  logic [WIDTH-1:0] rem;
  logic [2*WIDTH-1:0] result;

  assign accept    = (state == S_IDLE) && start;
  // Divide-by-zero leaves CALC on its first edge; otherwise after WIDTH steps.
  assign last_step = (state == S_CALC) && (dz || (count == CW'(WIDTH)));
  assign state_dbg = state;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (start) state_next = S_CALC;
      S_CALC:  if (last_step) state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // ---------------------------------------------------- shared adder
  always_comb begin
    shifted = {hi[WIDTH-1:0], lo[WIDTH-1]};
    add_a   = hi;
    add_sub = 1'b0;
    if (op_div) begin
      // Restoring trial subtraction of the divisor from the shifted remainder.
      add_a   = shifted;
      add_sub = 1'b1;
    end else begin
      // Booth pair {q0, q-1} = 10 subtracts, 01 adds.
      add_sub = lo[0] && !q_1;
    end
    sum = add_a + (add_sub ? ~m : m) + {{WIDTH{1'b0}}, add_sub};
  end

  assign booth_hi = (lo[0] ^ q_1) ? sum : hi;

  // Sign fix-up of the magnitude quotient / remainder.
  assign quot = neg_q ? -lo : lo;
  assign rem  = neg_r ? -hi[WIDTH-1:0] : hi[WIDTH-1:0];

  always_comb begin
    result = {hi[WIDTH-1:0], lo};
    if (dz)          result = {hi[WIDTH-1:0], {WIDTH{1'b1}}};
    else if (op_div) result = {rem, quot};
  end

  // ------------------------------------------------------- datapath
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out      <= '0;
      busy     <= 1'b0;
      finished <= 1'b0;
      div_zero <= 1'b0;
      count    <= '0;
      hi       <= '0;
      lo       <= '0;
      m        <= '0;
      q_1      <= 1'b0;
      op_div   <= 1'b0;
      dz       <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
    end else begin
      finished <= 1'b0;
      if (accept) begin
        busy     <= 1'b1;
        div_zero <= 1'b0;
        op_div   <= div;
        count    <= '0;
        q_1      <= 1'b0;
        neg_q    <= A[WIDTH-1] ^ B[WIDTH-1];
        neg_r    <= A[WIDTH-1];
        dz       <= div && (B == '0);
        if (div) begin
          lo <= A[WIDTH-1] ? -A : A;
          m  <= {1'b0, (B[WIDTH-1] ? -B : B)};
          // On divide-by-zero hi carries the raw dividend straight to out.
          hi <= (B == '0) ? {A[WIDTH-1], A} : '0;
        end else begin
          hi <= '0;
          lo <= B;
          m  <= {A[WIDTH-1], A};
        end
      end else if (state == S_CALC) begin
        if (last_step) begin
          out      <= result;
          finished <= 1'b1;
          busy     <= 1'b0;
          div_zero <= dz;
        end else begin
          count <= count + CW'(1);
          if (op_div) begin
            if (!sum[WIDTH]) begin
              hi <= sum;
              lo <= {lo[WIDTH-2:0], 1'b1};
            end else begin
              hi <= shifted;
              lo <= {lo[WIDTH-2:0], 1'b0};
            end
          end else begin
            hi  <= {booth_hi[WIDTH], booth_hi[WIDTH:1]};
            lo  <= {booth_hi[0], lo[WIDTH-1:1]};
            q_1 <= lo[0];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: self-checking bench for muldiv_unit. Directed vectors from a
// table, hand-written sequences for the multi-cycle corner cases (start while
// busy, start during DONE, asynchronous reset mid-operation) and randomized
// operations checked against a plain-arithmetic reference model.
module tb_muldiv_unit;

  localparam int W = 32;

  logic           clock    = 1'b0;
  logic           reset_n  = 1'b0;
  logic           start    = 1'b0;
  logic           div      = 1'b0;
  logic [W-1:0]   A        = '0;
  logic [W-1:0]   B        = '0;
  logic [2*W-1:0] out;
  logic           busy;
  logic           finished;
  logic           div_zero;
  logic [1:0]     state_dbg;

  int tests = 0;
  int fails = 0;
  logic [2*W-1:0] exp_q[$];

  typedef struct {
    logic        d;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
    logic        dz;
    string       name;
  } vec_t;

  vec_t vecs[8];

  muldiv_unit #(.WIDTH(W)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .start     (start),
    .div       (div),
    .A         (A),
    .B         (B),
    .out       (out),
    .busy      (busy),
    .finished  (finished),
    .div_zero  (div_zero),
    .state_dbg (state_dbg)
  );

  // ------------------------------------------------ clock / reset
  always #5 clock = ~clock;

  // ------------------------------------------------ reference model
  function automatic logic [63:0] model(input logic d, input logic [31:0] a,
                                        input logic [31:0] b);
    longint sa, sb, p, q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (!d) begin
      p = sa * sb;
      model = p;
    end else if (b == 32'd0) begin
      model = {a, 32'hFFFF_FFFF};
    end else begin
      q = sa / sb;   // truncates toward zero
      r = sa % sb;   // sign follows the dividend
      model = {r[31:0], q[31:0]};
    end
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       pick = 32'h8000_0000;
      1:       pick = 32'hFFFF_FFFF;
      2:       pick = 32'($urandom_range(0, 20));
      3:       pick = -32'($urandom_range(1, 20));
      default: pick = $urandom;
    endcase
  endfunction

  // ------------------------------------------------ checker
  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ------------------------------------------------ drivers
  task automatic issue(input logic d, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clock);
    start = 1'b1; div = d; A = a; B = b;
    @(posedge clock); #1;
    // Operands may change freely once accepted.
    start = 1'b0;
    div   = 1'($urandom_range(0, 1));
    A     = $urandom;
    B     = $urandom;
  endtask

  // Counts edges after the accepting edge until finished is seen.
  task automatic wait_fin(output int lat, output bit got, output int busy_low);
    lat = 0; got = 1'b0; busy_low = 0;
    while (!got && lat < 200) begin
      if (busy !== 1'b1) busy_low++;
      @(posedge clock); #1;
      lat++;
      if (finished === 1'b1) got = 1'b1;
    end
  endtask

  task automatic run_op(input logic d, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [2*W-1:0] exp_out, input logic exp_dz,
                        input string name);
    int lat;
    bit got;
    int busy_low;
    exp_q.push_back(exp_out);
    issue(d, a, b);
    check({name, " busy_on_accept"}, 64'(busy), 64'd1);
    check({name, " div_zero_cleared"}, 64'(div_zero), 64'd0);
    wait_fin(lat, got, busy_low);
    check({name, " finished_seen"}, 64'(got), 64'd1);
    check({name, " latency"}, 64'(lat), exp_dz ? 64'd1 : 64'(W + 1));
    check({name, " busy_during"}, 64'(busy_low), 64'd0);
    check({name, " out"}, out, exp_q.pop_front());
    check({name, " div_zero"}, 64'(div_zero), 64'(exp_dz));
    check({name, " busy_done"}, 64'(busy), 64'd0);
    @(posedge clock); #1;
    check({name, " single_pulse"}, 64'(finished), 64'd0);
    check({name, " out_hold"}, out, exp_out);
  endtask

  // ------------------------------------------------ test sequence
  initial begin
    int lat;
    bit got;
    int busy_low;
    int fin_count;
    int fin_edge;
    logic d;
    logic [31:0] a, b;

    vecs[0] = '{1'b0, 32'd6,          32'd7,          64'h0000_0000_0000_002A, 1'b0, "mul_6x7"};
    vecs[1] = '{1'b0, 32'hFFFF_FFFD,  32'd5,          64'hFFFF_FFFF_FFFF_FFF1, 1'b0, "mul_m3x5"};
    vecs[2] = '{1'b0, 32'h8000_0000,  32'h8000_0000,  64'h4000_0000_0000_0000, 1'b0, "mul_min_sq"};
    vecs[3] = '{1'b1, 32'd7,          32'hFFFF_FFFE,  64'h0000_0001_FFFF_FFFD, 1'b0, "div_7_m2"};
    vecs[4] = '{1'b1, 32'hFFFF_FFF9,  32'd2,          64'hFFFF_FFFF_FFFF_FFFD, 1'b0, "div_m7_2"};
    vecs[5] = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  64'h0000_0000_8000_0000, 1'b0, "div_min_m1"};
    vecs[6] = '{1'b1, 32'h0000_1234,  32'd0,          64'h0000_1234_FFFF_FFFF, 1'b1, "div_by_zero"};
    vecs[7] = '{1'b0, 32'd2,          32'd3,          64'h0000_0000_0000_0006, 1'b0, "mul_after_dz"};

    // Reset state.
    repeat (2) @(posedge clock);
    #1;
    check("reset out", out, 64'd0);
    check("reset busy", 64'(busy), 64'd0);
    check("reset finished", 64'(finished), 64'd0);
    check("reset div_zero", 64'(div_zero), 64'd0);
    @(negedge clock);
    reset_n = 1'b1;

    // Directed table.
    for (int i = 0; i < 8; i++)
      run_op(vecs[i].d, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].dz, vecs[i].name);

    // start pulsed at cycle 10 of a MUL is ignored.
    issue(1'b0, 32'd6, 32'd7);
    fin_count = 0;
    fin_edge  = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clock);
      start = (i == 10);
      if (i == 10) begin
        div = 1'b1; A = 32'd100; B = 32'd3;
      end
      @(posedge clock); #1;
      if (finished === 1'b1) begin
        fin_count++;
        fin_edge = i;
      end
    end
    start = 1'b0;
    check("busy_start pulses", 64'(fin_count), 64'd1);
    check("busy_start edge", 64'(fin_edge), 64'(W + 1));
    check("busy_start out", out, 64'h2A);
    check("busy_start idle_after", 64'(busy), 64'd0);

    // start held during the DONE cycle is ignored.
    issue(1'b0, 32'd5, 32'd5);
    wait_fin(lat, got, busy_low);
    check("done_start finished_seen", 64'(got), 64'd1);
    check("done_start out", out, 64'd25);
    start = 1'b1; div = 1'b0; A = 32'd9; B = 32'd9;
    @(posedge clock); #1;
    start = 1'b0;
    check("done_start not_accepted", 64'(busy), 64'd0);
    @(posedge clock); #1;
    check("done_start still_idle", 64'(busy), 64'd0);
    check("done_start no_pulse", 64'(finished), 64'd0);
    check("done_start out_hold", out, 64'd25);

    // Asynchronous reset in cycle 15 of a DIV.
    issue(1'b1, 32'd1000, 32'd7);
    repeat (14) @(posedge clock);
    #3;
    reset_n = 1'b0;
    #1;
    check("async_rst out", out, 64'd0);
    check("async_rst busy", 64'(busy), 64'd0);
    check("async_rst finished", 64'(finished), 64'd0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    fin_count = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clock); #1;
      if (finished === 1'b1) fin_count++;
    end
    check("async_rst no_finish", 64'(fin_count), 64'd0);
    run_op(1'b0, 32'd2, 32'd3, 64'd6, 1'b0, "mul_after_reset");

    // Randomized operations against the reference model.
    for (int i = 0; i < 40; i++) begin
      d = 1'($urandom_range(0, 1));
      a = pick();
      b = pick();
      if (d && ($urandom_range(0, 7) == 0)) b = 32'd0;
      run_op(d, a, b, model(d, a, b), d && (b == 32'd0), d ? "rand_div" : "rand_mul");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
